// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_pkg
//  Description : Shared constants, types and helpers for the seven-segment
//                scan driver: canonical active-low hex decode table, blank
//                segment pattern, blink phase encoding and counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

    // All segments dark in the canonical active-low form {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF_AL = 7'b1111111;

    // Blink phase: digits with blink set are dark while hidden
    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } blink_phase_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter width able to hold 0..count-1, never narrower than one bit
    function automatic int cnt_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg_al(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevseg_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_hex_decode
//  Description : Combinational hex nibble to seven-segment decoder, output in
//                canonical active-low {g,f,e,d,c,b,a} form.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; polarity is handled by the caller
    always_comb begin
        seg = hex_to_seg_al(nibble);
    end

endmodule
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_scan_driver
//  Description : Time-multiplexed N-digit seven-segment driver with hex
//                decode, per-digit decimal point, force blank, blink,
//                leading-zero blanking and anti-ghosting guard interval.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 8,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic                    lzb_en,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int DIV_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);
    localparam int FRM_W = cnt_width(BLINK_FRAMES);

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] c_guard    = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] c_frm_last = FRM_W'(BLINK_FRAMES - 1);

    // Pin-level "inactive" levels; the active-high board flavour inverts everything
    localparam logic                  c_active_low = (ACTIVE_LOW != 0);
    localparam logic [6:0]            c_seg_off    = c_active_low ? SEG_OFF_AL : 7'b0000000;
    localparam logic                  c_dp_off     = c_active_low;
    localparam logic [NUM_DIGITS-1:0] c_an_off     = c_active_low ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

    // Scan / blink state
    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic [FRM_W-1:0]        r_frm_cnt;
    blink_phase_t            r_phase;

    // Shadow copies of the display data
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [NUM_DIGITS-1:0]   r_blink;

    // Per-slot selection
    logic [3:0]              w_nibble;
    logic                    w_dp_req;
    logic                    w_blank_req;
    logic                    w_blink_req;
    logic [NUM_DIGITS-1:0]   w_an_onehot;
    logic [NUM_DIGITS-1:0]   w_lzb_mask;
    logic                    w_zero_above;
    logic                    w_lzb_sel;
    logic                    w_slot_on;
    logic [6:0]              w_seg_al;
    logic [6:0]              w_seg_next_al;
    logic                    w_dp_next_al;
    logic [NUM_DIGITS-1:0]   w_an_next_al;

    // Divider, digit index and blink frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_idx     <= '0;
            r_frm_cnt <= '0;
            r_phase   <= PHASE_VISIBLE;
            frame_o   <= 1'b0;
        end else begin
            frame_o <= 1'b0;
            if (r_div == c_div_last) begin
                r_div <= '0;
                if (r_idx == c_idx_last) begin
                    r_idx   <= '0;
                    frame_o <= 1'b1;
                    if (r_frm_cnt == c_frm_last) begin
                        r_frm_cnt <= '0;
                        r_phase   <= (r_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
                    end else begin
                        r_frm_cnt <= r_frm_cnt + 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Shadow capture; independent of the scan state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_blink <= '0;
        end else if (load) begin
            r_value <= value_i;
            r_dp    <= dp_i;
            r_blank <= blank_i;
            r_blink <= blink_i;
        end
    end

    // Pick the nibble and per-digit flags of the digit being scanned
    always_comb begin
        w_nibble    = 4'h0;
        w_dp_req    = 1'b0;
        w_blank_req = 1'b0;
        w_blink_req = 1'b0;
        w_an_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble       = r_value[4*k +: 4];
                w_dp_req       = r_dp[k];
                w_blank_req    = r_blank[k];
                w_blink_req    = r_blink[k];
                w_an_onehot[k] = 1'b1;
            end
        end
    end

    // Leading-zero mask: a digit is blanked while it and every higher nibble are zero;
    // digit 0 always stays visible so a zero value still shows "0"
    always_comb begin
        w_lzb_mask   = '0;
        w_zero_above = lzb_en;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above  = w_zero_above & (r_value[4*k +: 4] == 4'h0);
            w_lzb_mask[k] = w_zero_above;
        end
    end

    sevseg_hex_decode u_hex_decode (
        .nibble (w_nibble),
        .seg    (w_seg_al)
    );

    // Slot is lit only after the guard interval and when no blanking source applies
    always_comb begin
        w_lzb_sel     = |(w_lzb_mask & w_an_onehot);
        w_slot_on     = (r_div >= c_guard) &&
                        !(w_blank_req || w_lzb_sel ||
                          (w_blink_req && (r_phase == PHASE_HIDDEN)));
        w_seg_next_al = w_slot_on ? w_seg_al     : SEG_OFF_AL;
        w_dp_next_al  = w_slot_on ? ~w_dp_req    : 1'b1;
        w_an_next_al  = w_slot_on ? ~w_an_onehot : {NUM_DIGITS{1'b1}};
    end

    // Registered pin outputs with board polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_o <= c_seg_off;
            dp_o  <= c_dp_off;
            an_o  <= c_an_off;
        end else begin
            seg_o <= c_active_low ? w_seg_next_al : ~w_seg_next_al;
            dp_o  <= c_active_low ? w_dp_next_al  : ~w_dp_next_al;
            an_o  <= c_active_low ? w_an_next_al  : ~w_an_next_al;
        end
    end

endmodule
`default_nettype wire
